// File: rtl/obuf_pingpong_sat.sv
// Multi-bank partial-sum buffer with saturating narrowing of MAC results,
// rotating read bank for psum feedback, bias preload and a rounded,
// optionally ReLU-clamped store path with a sticky saturation flag.
module obuf_pingpong_sat #(
    parameter int MAC_NUM  = 112,
    parameter int ACC_W    = 33,
    parameter int ACC_FRAC = 24,
    parameter int BUF_W    = 28,
    parameter int BUF_FRAC = 24,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 12,
    parameter int NBANK    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       init_start,
    input  logic [NBANK*BUF_W-1:0]     bias,
    output logic                       init_busy,
    input  logic                       en,
    input  logic                       res_vld,
    output logic                       res_rdy,
    input  logic [MAC_NUM*ACC_W-1:0]   result_acc,
    output logic [MAC_NUM*BUF_W-1:0]   psum_out,
    input  logic                       store_en,
    input  logic                       relu_en,
    output logic [MAC_NUM*OUT_W-1:0]   store_data,
    output logic                       store_vld,
    output logic                       sat_flag
);
    localparam int PTR_W = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int BSH   = ACC_FRAC - BUF_FRAC;
    localparam int SSH   = ACC_FRAC - OUT_FRAC;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NBANK - 1);
    // Saturation limits expressed at ACC_W+1 bits so signed compares are exact
    localparam logic signed [ACC_W:0] BUF_MAX = {{(ACC_W+2-BUF_W){1'b0}}, {(BUF_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] BUF_MIN = ~BUF_MAX;
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0] ptr_q, wb;
    logic             store_vld_q, sat_q;
    logic             accept, buf_we, st_we;
    logic [MAC_NUM-1:0] buf_sat_v, st_sat_v;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state, preload counter and handshake outputs; init_start always wins
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_busy  = (state_q == S_INIT);
        res_rdy    = (state_q != S_INIT) && !init_start;
        case (state_q)
            S_IDLE: state_d = S_RUN;
            S_INIT: begin
                if (init_cnt_q == PTR_LAST) begin
                    state_d    = S_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
        if (init_start) begin
            state_d    = S_INIT;
            init_cnt_d = '0;
        end
    end

    assign accept = res_vld && res_rdy;
    assign buf_we = accept && (state_q == S_RUN);
    assign st_we  = accept && store_en;
    // Write bank trails the read bank by one position
    assign wb     = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;

    // Read-bank pointer: rotates while enabled, parked at bank 0 otherwise
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    // Store strobe and sticky saturation flag (cleared at the first preload cycle)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            store_vld_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            store_vld_q <= st_we;
            if (state_q == S_INIT && init_cnt_q == '0) begin
                sat_q <= 1'b0;
            end else if ((buf_we && |buf_sat_v) || (st_we && |st_sat_v)) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign store_vld = store_vld_q;
    assign sat_flag  = sat_q;

    for (genvar gi = 0; gi < MAC_NUM; gi++) begin : g_lane
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W:0]   buf_sh, st_sh, st_rnd;
        logic                    buf_hi, buf_lo, st_hi, st_lo;
        logic [BUF_W-1:0]        buf_word;
        logic [OUT_W-1:0]        st_word;
        logic [BUF_W-1:0]        bank_q [NBANK];
        logic [OUT_W-1:0]        store_q;

        assign acc    = result_acc[gi*ACC_W +: ACC_W];
        // One extra bit of headroom so the round-up carry never wraps
        assign buf_sh = $signed({acc[ACC_W-1], acc}) >>> BSH;
        assign st_sh  = $signed({acc[ACC_W-1], acc}) >>> SSH;
        assign st_rnd = st_sh + $signed({{ACC_W{1'b0}}, acc[SSH-1]});

        assign buf_hi   = buf_sh > BUF_MAX;
        assign buf_lo   = buf_sh < BUF_MIN;
        assign buf_word = buf_hi ? {1'b0, {(BUF_W-1){1'b1}}} :
                          buf_lo ? {1'b1, {(BUF_W-1){1'b0}}} : buf_sh[BUF_W-1:0];
        assign buf_sat_v[gi] = buf_hi | buf_lo;

        assign st_hi   = st_rnd > OUT_MAX;
        assign st_lo   = st_rnd < OUT_MIN;
        assign st_word = st_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                         st_lo ? {1'b1, {(OUT_W-1){1'b0}}} : st_rnd[OUT_W-1:0];
        assign st_sat_v[gi] = st_hi | st_lo;

        // Bank storage: bias preload has priority, then accepted results
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int b = 0; b < NBANK; b++) begin
                    bank_q[b] <= '0;
                end
            end else if (state_q == S_INIT) begin
                bank_q[init_cnt_q] <= bias[init_cnt_q*BUF_W +: BUF_W];
            end else if (buf_we) begin
                bank_q[wb] <= buf_word;
            end
        end

        // Store word register, ReLU applied after saturation; holds between beats
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                store_q <= '0;
            end else if (st_we) begin
                store_q <= (relu_en && acc[ACC_W-1]) ? '0 : st_word;
            end
        end

        assign psum_out[gi*BUF_W +: BUF_W]   = bank_q[ptr_q];
        assign store_data[gi*OUT_W +: OUT_W] = store_q;
    end

endmodule

// File: tb/tb_obuf_pingpong_sat.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against an arithmetic model of the buffer.
module tb_obuf_pingpong_sat;
    localparam int MAC = 8, ACC_W = 33, ACC_FRAC = 24, BUF_W = 28, BUF_FRAC = 24;
    localparam int OUT_W = 16, OUT_FRAC = 12, NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n = 1'b0, init_start = 1'b0, en = 1'b0, res_vld = 1'b0;
    logic                   store_en = 1'b0, relu_en = 1'b0;
    logic [NB*BUF_W-1:0]    bias = '0;
    logic [MAC*ACC_W-1:0]   result_acc = '0;
    logic                   init_busy, res_rdy, store_vld, sat_flag;
    logic [MAC*BUF_W-1:0]   psum_out;
    logic [MAC*OUT_W-1:0]   store_data;

    obuf_pingpong_sat #(
        .MAC_NUM(MAC), .ACC_W(ACC_W), .ACC_FRAC(ACC_FRAC), .BUF_W(BUF_W),
        .BUF_FRAC(BUF_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC), .NBANK(NB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .bias(bias),
        .init_busy(init_busy), .en(en), .res_vld(res_vld), .res_rdy(res_rdy),
        .result_acc(result_acc), .psum_out(psum_out), .store_en(store_en),
        .relu_en(relu_en), .store_data(store_data), .store_vld(store_vld),
        .sat_flag(sat_flag)
    );

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_phase = 0;   // 0 idle, 1 preload, 2 run
    int               m_k = 0, m_ptr = 0;
    logic [BUF_W-1:0] m_bank [NB][MAC];
    logic [OUT_W-1:0] m_sd [MAC];
    bit               m_sv = 0, m_sat = 0;

    function automatic longint clip(longint v, int w);
        longint mx = (longint'(1) << (w - 1)) - 1;
        longint mn = -mx - 1;
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    function automatic longint lane_val(int l);
        logic signed [ACC_W-1:0] t = result_acc[l*ACC_W +: ACC_W];
        return longint'(t);
    endfunction

    bit     md_rdy, md_acc, md_ns;
    longint md_v, md_b, md_s;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_k = 0; m_ptr = 0; m_sv = 0; m_sat = 0;
            for (int b = 0; b < NB; b++)
                for (int l = 0; l < MAC; l++) m_bank[b][l] = '0;
            for (int l = 0; l < MAC; l++) m_sd[l] = '0;
        end else begin
            md_ns  = 0;
            md_rdy = (m_phase != 1) && !init_start;
            md_acc = res_vld && md_rdy;
            if (m_phase == 1)
                for (int l = 0; l < MAC; l++) m_bank[m_k][l] = bias[m_k*BUF_W +: BUF_W];
            m_sv = md_acc && store_en;
            for (int l = 0; l < MAC; l++) begin
                md_v = lane_val(l);
                if (md_acc && m_phase == 2) begin
                    md_b = md_v >>> (ACC_FRAC - BUF_FRAC);
                    if (clip(md_b, BUF_W) != md_b) md_ns = 1;
                    m_bank[(m_ptr + NB - 1) % NB][l] = BUF_W'(clip(md_b, BUF_W));
                end
                if (m_sv) begin
                    // round half-up == floor((v + half LSB) / LSB)
                    md_s = (md_v + (longint'(1) << (ACC_FRAC - OUT_FRAC - 1))) >>> (ACC_FRAC - OUT_FRAC);
                    if (clip(md_s, OUT_W) != md_s) md_ns = 1;
                    m_sd[l] = (relu_en && md_v < 0) ? '0 : OUT_W'(clip(md_s, OUT_W));
                end
            end
            if (m_phase == 1 && m_k == 0) m_sat = 0;
            else if (md_ns) m_sat = 1;
            m_ptr = en ? (m_ptr + 1) % NB : 0;
            if (init_start) begin
                m_phase = 1; m_k = 0;
            end else if (m_phase == 0) begin
                m_phase = 2;
            end else if (m_phase == 1) begin
                if (m_k == NB - 1) begin m_phase = 2; m_k = 0; end
                else m_k++;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("init_busy", 64'(init_busy), 64'(m_phase == 1));
            chk("res_rdy", 64'(res_rdy), 64'((m_phase != 1) && !init_start));
            chk("store_vld", 64'(store_vld), 64'(m_sv));
            chk("sat_flag", 64'(sat_flag), 64'(m_sat));
            for (int l = 0; l < MAC; l++) begin
                chk("psum_out", 64'(psum_out[l*BUF_W +: BUF_W]), 64'(m_bank[m_ptr][l]));
                chk("store_data", 64'(store_data[l*OUT_W +: OUT_W]), 64'(m_sd[l]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(int l, longint v);
        result_acc[l*ACC_W +: ACC_W] = ACC_W'(v);
    endtask

    int nb;
    longint rv;
    initial begin
        // reset
        tick(); tick();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_vld", 64'(store_vld), 64'd0);
        chk("rst_busy", 64'(init_busy), 64'd0);
        chk("rst_psum", 64'(psum_out[BUF_W-1:0]), 64'd0);
        rst_n = 1'b1;
        tick(); tick();

        // bias preload
        bias = {28'h0100000, 28'hFF00000};
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        nb = 0;
        repeat (5) begin
            @(negedge clk);
            if (init_busy) nb++;
            tick();
        end
        chk("init_busy_len", 64'(nb), 64'd2);
        @(negedge clk);
        chk("bias_bank0_l0", 64'(psum_out[BUF_W-1:0]), 64'h0FF00000);
        chk("bias_bank0_l7", 64'(psum_out[7*BUF_W +: BUF_W]), 64'h0FF00000);

        // streamed +3.0 with rotation
        set_lane(0, 64'sh3000000);
        res_vld = 1'b1; en = 1'b1;
        repeat (4) tick();
        res_vld = 1'b0; en = 1'b0;
        tick();
        @(negedge clk);
        chk("run_bank0", 64'(psum_out[BUF_W-1:0]), 64'h3000000);
        chk("run_sat", 64'(sat_flag), 64'd0);
        en = 1'b1;
        tick();
        @(negedge clk);
        chk("run_bank1", 64'(psum_out[BUF_W-1:0]), 64'h3000000);
        en = 1'b0;
        tick();

        // buffer saturation +9.0 / -9.0 (written to bank 1 while ptr=0)
        set_lane(0, 64'sh9000000);
        res_vld = 1'b1;
        tick();
        res_vld = 1'b0; en = 1'b1;
        tick();
        @(negedge clk);
        chk("sat_pos_word", 64'(psum_out[BUF_W-1:0]), 64'h7FFFFFF);
        chk("sat_pos_flag", 64'(sat_flag), 64'd1);
        en = 1'b0;
        tick();
        set_lane(0, -64'sh9000000);
        res_vld = 1'b1;
        tick();
        res_vld = 1'b0; en = 1'b1;
        tick();
        @(negedge clk);
        chk("sat_neg_word", 64'(psum_out[BUF_W-1:0]), 64'h8000000);
        en = 1'b0;
        tick();

        // store rounding carrying past the maximum
        set_lane(0, 64'sh7FFF800);
        store_en = 1'b1; res_vld = 1'b1;
        @(negedge clk);
        chk("st_vld_before", 64'(store_vld), 64'd0);
        tick();
        store_en = 1'b0; res_vld = 1'b0;
        @(negedge clk);
        chk("st_round_sat", 64'(store_data[OUT_W-1:0]), 64'h7FFF);
        chk("st_vld_pulse", 64'(store_vld), 64'd1);
        tick();
        @(negedge clk);
        chk("st_vld_drop", 64'(store_vld), 64'd0);
        chk("st_hold", 64'(store_data[OUT_W-1:0]), 64'h7FFF);

        // ReLU on -1.5, then the same beat without ReLU
        set_lane(0, -64'sh1800000);
        store_en = 1'b1; relu_en = 1'b1; res_vld = 1'b1;
        tick();
        relu_en = 1'b0;
        @(negedge clk);
        chk("relu_on", 64'(store_data[OUT_W-1:0]), 64'h0000);
        tick();
        res_vld = 1'b0; store_en = 1'b0;
        @(negedge clk);
        chk("relu_off", 64'(store_data[OUT_W-1:0]), 64'hE800);

        // init_start colliding with a valid beat
        set_lane(0, 64'sh9000000);
        res_vld = 1'b1;
        tick();
        init_start = 1'b1;
        @(negedge clk);
        chk("collide_rdy", 64'(res_rdy), 64'd0);
        tick();
        init_start = 1'b0; res_vld = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("collide_sat_clr", 64'(sat_flag), 64'd0);
        chk("collide_bank0", 64'(psum_out[BUF_W-1:0]), 64'hFF00000);
        en = 1'b1;
        tick();
        @(negedge clk);
        chk("collide_bank1", 64'(psum_out[BUF_W-1:0]), 64'h0100000);
        en = 1'b0;
        tick();

        // reset in the middle of a preload
        bias = {28'h1234567, 28'h7654321};
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("midinit_rst_b0", 64'(psum_out[BUF_W-1:0]), 64'd0);
        chk("midinit_rst_busy", 64'(init_busy), 64'd0);
        rst_n = 1'b1; en = 1'b1;
        tick();
        @(negedge clk);
        chk("midinit_rst_b1", 64'(psum_out[BUF_W-1:0]), 64'd0);
        en = 1'b0;
        tick();

        // randomized traffic
        repeat (800) begin
            rst_n      = ($urandom_range(0, 149) != 0);
            init_start = ($urandom_range(0, 29) == 0);
            res_vld    = $urandom_range(0, 1) == 1;
            en         = ($urandom_range(0, 3) != 0);
            store_en   = $urandom_range(0, 1) == 1;
            relu_en    = $urandom_range(0, 1) == 1;
            for (int b = 0; b < NB; b++) bias[b*BUF_W +: BUF_W] = BUF_W'($urandom);
            for (int l = 0; l < MAC; l++) begin
                case ($urandom_range(0, 2))
                    0: rv = longint'({$urandom, $urandom});
                    1: rv = longint'($urandom_range(0, 536870912)) - 64'sd268435456;
                    default: rv = 64'sh7FFF800 + longint'($urandom_range(0, 4095)) - 64'sd2048;
                endcase
                if ($urandom_range(0, 3) == 0) rv = -rv;
                set_lane(l, rv);
            end
            tick();
        end
        rst_n = 1'b1; init_start = 1'b0; res_vld = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
